// File: rtl/acc_scheduler_if.sv
// rtl/acc_scheduler_if.sv - request and accumulator channels of the accumulator scheduler
interface acc_scheduler_if #(
    parameter int N_REQ = 2,
    parameter int N_ACC = 3
);
    localparam int AW = (N_ACC > 1) ? $clog2(N_ACC) : 1;

    logic [N_REQ-1:0] req_valid;
    logic [AW-1:0]    req_acc  [N_REQ];
    logic [31:0]      req_data [N_REQ];
    logic [N_REQ-1:0] req_ready;

    logic [N_ACC-1:0] acc_valid;
    logic [31:0]      acc_data [N_ACC];
    logic [N_ACC-1:0] acc_ready;

    modport master (
        output req_valid, req_acc, req_data, acc_ready,
        input  req_ready, acc_valid, acc_data
    );

    modport slave (
        input  req_valid, req_acc, req_data, acc_ready,
        output req_ready, acc_valid, acc_data
    );
endinterface

// File: rtl/acc_scheduler.sv
// rtl/acc_scheduler.sv - per-accumulator round-robin arbitration, FIFOs and drain sequencer
module acc_scheduler #(
    parameter int N_REQ = 2,
    parameter int N_ACC = 3,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    acc_scheduler_if.slave bus,
    input  logic           acc_idle,
    input  logic           drain_req,
    output logic           draining,
    output logic           drain_done,
    output logic           no_pending
);
    localparam int AW = (N_ACC > 1) ? $clog2(N_ACC) : 1;
    localparam int RW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, SETTLE, DONE} state_t;

    state_t           state, state_nxt;
    logic             grant_en;
    logic [RW-1:0]    ptr       [N_ACC];
    logic [PW-1:0]    rd_ptr    [N_ACC];
    logic [PW-1:0]    wr_ptr    [N_ACC];
    logic [CW-1:0]    count     [N_ACC];
    logic [31:0]      mem       [N_ACC][DEPTH];
    logic [N_ACC-1:0] gnt_valid;
    logic [RW-1:0]    gnt_idx   [N_ACC];
    logic [RW-1:0]    cand;
    logic [N_REQ-1:0] ready;
    logic [N_ACC-1:0] valid;
    logic [N_ACC-1:0] pop;

    // Search from ptr[k]; a full FIFO refuses even if it is popping this cycle.
    always_comb begin
        cand = '0;
        for (int k = 0; k < N_ACC; k++) begin
            gnt_valid[k] = 1'b0;
            gnt_idx[k]   = '0;
            if (grant_en && count[k] < CW'(DEPTH)) begin
                for (int i = 0; i < N_REQ; i++) begin
                    cand = RW'((int'(ptr[k]) + i) % N_REQ);
                    if (!gnt_valid[k] && bus.req_valid[cand] && bus.req_acc[cand] == AW'(k)) begin
                        gnt_valid[k] = 1'b1;
                        gnt_idx[k]   = cand;
                    end
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int r = 0; r < N_REQ; r++) begin
            for (int k = 0; k < N_ACC; k++) begin
                if (gnt_valid[k] && gnt_idx[k] == RW'(r)) begin
                    ready[r] = 1'b1;
                end
            end
        end
    end

    assign bus.req_ready = ready;

    always_comb begin
        no_pending = 1'b1;
        for (int k = 0; k < N_ACC; k++) begin
            valid[k]        = (count[k] != '0);
            pop[k]          = valid[k] && bus.acc_ready[k];
            bus.acc_data[k] = mem[k][rd_ptr[k]];
            if (valid[k]) begin
                no_pending = 1'b0;
            end
        end
    end

    assign bus.acc_valid = valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_ACC; k++) begin
                ptr[k]    <= '0;
                rd_ptr[k] <= '0;
                wr_ptr[k] <= '0;
                count[k]  <= '0;
                for (int d = 0; d < DEPTH; d++) begin
                    mem[k][d] <= '0;
                end
            end
        end else begin
            for (int k = 0; k < N_ACC; k++) begin
                if (gnt_valid[k]) begin
                    mem[k][wr_ptr[k]] <= bus.req_data[gnt_idx[k]];
                    wr_ptr[k]         <= wr_ptr[k] + 1'b1;
                    ptr[k]            <= (gnt_idx[k] == RW'(N_REQ - 1)) ? '0 : gnt_idx[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
                case ({gnt_valid[k], pop[k]})
                    2'b10:   count[k] <= count[k] + 1'b1;
                    2'b01:   count[k] <= count[k] - 1'b1;
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (drain_req)  state_nxt = DRAIN;
            DRAIN:   if (no_pending) state_nxt = SETTLE;
            SETTLE:  if (acc_idle)   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_en   = (state == IDLE);
        draining   = (state != IDLE);
        drain_done = (state == DONE);
    end
endmodule

// File: tb/tb_acc_scheduler.sv
// tb/tb_acc_scheduler.sv - randomized bench for acc_scheduler against a queue-based reference model
module tb_acc_scheduler;
    localparam int N_REQ = 2;
    localparam int N_ACC = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    logic acc_idle;
    logic drain_req;
    logic draining;
    logic drain_done;
    logic no_pending;

    acc_scheduler_if #(.N_REQ(N_REQ), .N_ACC(N_ACC)) bus ();

    acc_scheduler #(.N_REQ(N_REQ), .N_ACC(N_ACC), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .acc_idle   (acc_idle),
        .drain_req  (drain_req),
        .draining   (draining),
        .drain_done (drain_done),
        .no_pending (no_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] q [N_ACC][$];
    int          rr [N_ACC];
    int          phase;
    int          grant_cnt [N_REQ];
    int          mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N_ACC; k++) begin
            q[k].delete();
            rr[k] = 0;
        end
        phase = 0;
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_acc_valid", 64'(bus.acc_valid), 64'd0);
        for (int k = 0; k < N_ACC; k++) check("rst_acc_data", 64'(bus.acc_data[k]), 64'd0);
        check("rst_draining", 64'(draining), 64'd0);
        check("rst_drain_done", 64'(drain_done), 64'd0);
        check("rst_no_pending", 64'(no_pending), 64'd1);
    endtask

    // Evaluate one cycle of the reference: predict outputs, compare, then commit the clock edge.
    task automatic model_step();
        logic [N_REQ-1:0] exp_ready;
        logic [N_ACC-1:0] exp_valid;
        int               winner [N_ACC];
        bit               all_empty;
        exp_ready = '0;
        exp_valid = '0;
        all_empty = 1'b1;
        for (int k = 0; k < N_ACC; k++) begin
            winner[k] = -1;
            if (q[k].size() > 0) begin
                exp_valid[k] = 1'b1;
                all_empty    = 1'b0;
            end
            if (phase == 0 && q[k].size() < DEPTH) begin
                for (int i = 0; i < N_REQ && winner[k] < 0; i++) begin
                    int r;
                    r = (rr[k] + i) % N_REQ;
                    if (bus.req_valid[r] && int'(bus.req_acc[r]) == k) winner[k] = r;
                end
            end
            if (winner[k] >= 0) exp_ready[winner[k]] = 1'b1;
        end

        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("acc_valid", 64'(bus.acc_valid), 64'(exp_valid));
        for (int k = 0; k < N_ACC; k++)
            if (exp_valid[k]) check("acc_data", 64'(bus.acc_data[k]), 64'(q[k][0]));
        check("no_pending", 64'(no_pending), 64'(all_empty));
        check("draining", 64'(draining), 64'(phase != 0));
        check("drain_done", 64'(drain_done), 64'(phase == 3));

        if (mode == 0)
            for (int r = 0; r < N_REQ; r++) grant_cnt[r] += int'(bus.req_ready[r]);

        for (int k = 0; k < N_ACC; k++) begin
            if (exp_valid[k] && bus.acc_ready[k]) void'(q[k].pop_front());
            if (winner[k] >= 0) begin
                q[k].push_back(bus.req_data[winner[k]]);
                rr[k] = (winner[k] + 1) % N_REQ;
            end
        end
        case (phase)
            0: if (drain_req) phase = 1;
            1: if (all_empty) phase = 2;
            2: if (acc_idle) phase = 3;
            default: phase = 0;
        endcase
    endtask

    task automatic drive();
        drain_req = 1'b0;
        acc_idle  = 1'b1;
        for (int r = 0; r < N_REQ; r++) bus.req_data[r] = $urandom;
        case (mode)
            0: begin
                bus.req_valid = '1;
                for (int r = 0; r < N_REQ; r++) bus.req_acc[r] = 2'd1;
                bus.acc_ready = '1;
            end
            1: begin
                bus.req_valid = N_REQ'($urandom);
                for (int r = 0; r < N_REQ; r++) bus.req_acc[r] = 2'($urandom_range(0, N_ACC - 1));
                for (int k = 0; k < N_ACC; k++) bus.acc_ready[k] = ($urandom_range(0, 9) < 6);
                drain_req = ($urandom_range(0, 14) == 0);
                acc_idle  = ($urandom_range(0, 3) != 0);
            end
            2: begin
                bus.req_valid = N_REQ'($urandom);
                for (int r = 0; r < N_REQ; r++) bus.req_acc[r] = 2'($urandom_range(0, N_ACC - 1));
                bus.acc_ready = '0;
            end
            3: begin
                bus.req_valid = '0;
                bus.acc_ready = '1;
            end
            default: begin
                bus.req_valid = 2'b01;
                bus.req_acc[0] = 2'd0;
                bus.acc_ready = '0;
                drain_req = (mode == 5);
            end
        endcase
    endtask

    task automatic run(input int m, input int n);
        mode = m;
        for (int c = 0; c < n; c++) begin
            drive();
            @(negedge clk);
            model_step();
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        acc_idle = 1'b1;
        drain_req = 1'b0;
        bus.req_valid = '0;
        bus.acc_ready = '0;
        for (int r = 0; r < N_REQ; r++) begin
            bus.req_acc[r]  = '0;
            bus.req_data[r] = '0;
        end
        for (int r = 0; r < N_REQ; r++) grant_cnt[r] = 0;
        mode = 3;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        run(0, 40);
        check("fair_r0", 64'(grant_cnt[0]), 64'd20);
        check("fair_r1", 64'(grant_cnt[1]), 64'd20);

        run(2, 12);
        run(1, 300);
        run(2, 10);
        run(1, 200);

        run(3, 10);
        run(4, 2);
        run(5, 1);
        run(4, 1);
        check("mid_drain", 64'(draining), 64'd1);
        reset = 1'b1;
        bus.req_valid = '0;
        #1;
        check_reset_values();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run(1, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
